// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-stage instruction decoder with load-use interlock and flush
// Decodes one instruction into a registered control bundle behind a valid/ready handshake.
module decode_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic              flush,
   output logic              rf_en,
   output logic [ADDR_W-1:0] rf_addr1,
   output logic [ADDR_W-1:0] rf_addr2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_rd,
   output logic [DATA_W-1:0] out_imm,
   output logic [3:0]        out_alu_op,
   output logic              out_use_imm,
   output logic              out_wr_en,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic              out_branch,
   output logic              out_illegal
);

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h01;
   localparam logic [5:0] OP_LOAD  = 6'h02;
   localparam logic [5:0] OP_STORE = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rd, rs1, rs2;
   logic [DATA_W-1:0] d_imm;
   logic [3:0]        d_alu_op;
   logic              d_use_imm, d_wr_en, d_mem_rd, d_mem_wr, d_branch, d_illegal;
   logic              use_rs1, use_rs2;
   logic              load_use, accept;

   assign opcode = in_instr[31:26];
   assign rd     = in_instr[21 +: ADDR_W];
   assign rs1    = in_instr[16 +: ADDR_W];
   assign rs2    = in_instr[11 +: ADDR_W];
   assign d_imm  = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};

   always_comb begin
      d_alu_op  = 4'd0;
      d_use_imm = 1'b0;
      d_wr_en   = 1'b0;
      d_mem_rd  = 1'b0;
      d_mem_wr  = 1'b0;
      d_branch  = 1'b0;
      d_illegal = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      case (opcode)
         OP_R: begin
            d_alu_op = in_instr[3:0];
            d_wr_en  = 1'b1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
         end
         OP_ADDI: begin
            d_use_imm = 1'b1;
            d_wr_en   = 1'b1;
            use_rs1   = 1'b1;
         end
         OP_LOAD: begin
            d_use_imm = 1'b1;
            d_wr_en   = 1'b1;
            d_mem_rd  = 1'b1;
            use_rs1   = 1'b1;
         end
         OP_STORE: begin
            d_use_imm = 1'b1;
            d_mem_wr  = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
         end
         OP_BEQ: begin
            d_alu_op = 4'd1;
            d_branch = 1'b1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
   end

   // A held load whose result the incoming instruction reads must leave before it is accepted.
   assign load_use = out_valid & out_mem_rd & (out_rd != '0) & in_valid &
                     ((use_rs1 & (rs1 == out_rd)) | (use_rs2 & (rs2 == out_rd)));

   assign in_ready = rst_n & (~out_valid | out_ready) & ~load_use & ~flush;
   assign accept   = in_valid & in_ready;
   assign rf_en    = accept;
   assign rf_addr1 = rs1;
   assign rf_addr2 = rs2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_rd      <= '0;
         out_imm     <= '0;
         out_alu_op  <= 4'd0;
         out_use_imm <= 1'b0;
         out_wr_en   <= 1'b0;
         out_mem_rd  <= 1'b0;
         out_mem_wr  <= 1'b0;
         out_branch  <= 1'b0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_rd      <= rd;
         out_imm     <= d_imm;
         out_alu_op  <= d_alu_op;
         out_use_imm <= d_use_imm;
         out_wr_en   <= d_wr_en;
         out_mem_rd  <= d_mem_rd;
         out_mem_wr  <= d_mem_wr;
         out_branch  <= d_branch;
         out_illegal <= d_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
// Driver predicts acceptance from a reference model; monitor checks each delivered bundle.
module tb_decode_stage;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        use_imm, wr_en, mem_rd, mem_wr, branch, illegal;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready, rf_en, out_valid;
   logic [4:0]  rf_addr1, rf_addr2, out_rd;
   logic [31:0] out_imm;
   logic [3:0]  out_alu_op;
   logic        out_use_imm, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_illegal;

   int checks = 0;
   int errors = 0;
   bundle_t q[$];

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .flush(flush), .rf_en(rf_en), .rf_addr1(rf_addr1),
      .rf_addr2(rf_addr2), .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_imm(out_imm), .out_alu_op(out_alu_op),
      .out_use_imm(out_use_imm), .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd),
      .out_mem_wr(out_mem_wr), .out_branch(out_branch), .out_illegal(out_illegal)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: opcode table giving control bits and which source registers are read.
   function automatic bundle_t ref_bundle(input logic [31:0] i);
      bundle_t b;
      b = '0;
      b.rd  = i[25:21];
      b.imm = 32'($signed(i[15:0]));
      case (i[31:26])
         6'd0: begin b.alu = i[3:0]; b.wr_en = 1'b1; end
         6'd1: begin b.use_imm = 1'b1; b.wr_en = 1'b1; end
         6'd2: begin b.use_imm = 1'b1; b.wr_en = 1'b1; b.mem_rd = 1'b1; end
         6'd3: begin b.use_imm = 1'b1; b.mem_wr = 1'b1; end
         6'd4: begin b.alu = 4'd1; b.branch = 1'b1; end
         default: b.illegal = 1'b1;
      endcase
      return b;
   endfunction

   function automatic logic [1:0] ref_uses(input logic [31:0] i);
      if (i[31:26] == 6'd1 || i[31:26] == 6'd2) return 2'b10;
      if (i[31:26] <= 6'd4) return 2'b11;
      return 2'b00;
   endfunction

   function automatic bundle_t dut_bundle();
      return {out_rd, out_imm, out_alu_op, out_use_imm, out_wr_en,
              out_mem_rd, out_mem_wr, out_branch, out_illegal};
   endfunction

   task automatic cycle(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
      bundle_t    h, d;
      logic [1:0] u;
      logic       held, lu, er;
      @(negedge clk);
      in_valid = v; in_instr = ins; flush = fl; out_ready = rdy;
      #1;
      held = (q.size() != 0);
      h = held ? q[0] : '0;
      d = ref_bundle(ins);
      u = ref_uses(ins);
      lu = held && h.mem_rd && (h.rd != 0) && v &&
           ((u[1] && ins[20:16] == h.rd) || (u[0] && ins[15:11] == h.rd));
      er = (!held || rdy) && !lu && !fl;
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("rf_en", 64'(rf_en), 64'(v && er));
      chk("rf_addr1", 64'(rf_addr1), 64'(ins[20:16]));
      chk("rf_addr2", 64'(rf_addr2), 64'(ins[15:11]));
      @(posedge clk);
      #1;
      if (fl) begin
         if (q.size() != 0) q.delete(0);
      end else if (v && er) begin
         q.push_back(d);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      in_valid = 1'b1;
      q.delete();
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_bundle", 64'(dut_bundle()), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_rf_en", 64'(rf_en), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 4));
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom)};
   endfunction

   // Monitor: out_valid must track the scoreboard, and each delivered bundle must match its head.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (out_valid && out_ready && !flush && q.size() != 0) begin
               chk("bundle", 64'(dut_bundle()), 64'(q[0]));
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #1;
      chk("init_in_ready", 64'(in_ready), 64'd0);
      chk("init_out_valid", 64'(out_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      cycle(1'b1, 32'h0443FFFE, 1'b0, 1'b1);
      chk("addi_imm", 64'(out_imm), 64'hFFFFFFFE);
      chk("addi_rd", 64'(out_rd), 64'd2);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      cycle(1'b1, 32'h08A10004, 1'b0, 1'b1);
      cycle(1'b1, 32'h00C72802, 1'b0, 1'b1);
      cycle(1'b1, 32'h00C72802, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      cycle(1'b1, 32'h08010004, 1'b0, 1'b1);
      cycle(1'b1, 32'h00C01802, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      cycle(1'b1, 32'h04221234, 1'b0, 1'b1);
      repeat (3) cycle(1'b1, 32'h00432002, 1'b0, 1'b0);
      cycle(1'b1, 32'h00432002, 1'b0, 1'b1);

      cycle(1'b1, 32'h0C641111, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      cycle(1'b1, 32'hFC000000, 1'b0, 1'b1);
      cycle(1'b1, 32'h04221234, 1'b0, 1'b0);
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         cycle(1'($urandom_range(0, 3) != 0), rand_instr(),
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("drained", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and instruction width (fixed at 32; other values unsupported).
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (fixed at 5).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports:
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  decode accepts this cycle
- in_instr  input  DATA_W  instruction word
- flush  input  1  kill the held and incoming instruction
- rf_en  output  1  register-file enable
- rf_addr1  output  ADDR_W  register-file read index 1
- rf_addr2  output  ADDR_W  register-file read index 2
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts bundle
- out_rd  output  ADDR_W  destination index
- out_imm  output  DATA_W  sign-extended immediate
- out_alu_op  output  4  ALU operation
- out_use_imm  output  1  operand B is immediate
- out_wr_en  output  1  writes rd
- out_mem_rd  output  1  load
- out_mem_wr  output  1  store
- out_branch  output  1  BEQ
- out_illegal  output  1  undefined opcode

Function
REQ-005 SHALL decode fields: opcode=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], funct=[3:0], imm=sign-extended [15:0].
REQ-006 SHALL decode opcodes:
- 0x00 R-type: alu_op=funct, wr_en=1, uses rs1 and rs2
- 0x01 ADDI: alu_op=0, use_imm=1, wr_en=1, uses rs1
- 0x02 LOAD: alu_op=0, use_imm=1, wr_en=1, mem_rd=1, uses rs1
- 0x03 STORE: alu_op=0, use_imm=1, mem_wr=1, uses rs1 and rs2
- 0x04 BEQ: alu_op=1, branch=1, uses rs1 and rs2
- other: illegal=1, all other control bits 0, uses neither
REQ-007 SHALL drive rf_addr1=in_instr[20:16] and rf_addr2=in_instr[15:11] combinationally.
REQ-008 SHALL drive rf_en = in_valid & in_ready, so register data arrives one cycle later, aligned with the registered bundle.
REQ-009 SHALL compute load_use = out_valid & out_mem_rd & (out_rd!=0) & in_valid & ((rs1 used & rs1==out_rd) | (rs2 used & rs2==out_rd)).
REQ-010 SHALL compute in_ready = (~out_valid | out_ready) & ~load_use & ~flush.
REQ-011 SHALL on a clock edge with in_valid & in_ready load the decoded bundle and set out_valid=1 (latency 1 cycle).
REQ-012 SHALL on a clock edge with out_valid & out_ready and no acceptance clear out_valid; this includes the single bubble inserted on load_use.
REQ-013 SHALL hold all bundle outputs stable while out_valid & ~out_ready.
REQ-014 SHALL on a clock edge with flush=1 clear out_valid, regardless of out_ready, load_use or in_valid; flush has priority over acceptance.
REQ-015 SHALL make load_use stall for exactly one cycle when out_ready=1; with out_ready=0 the stall lasts until the load leaves.
REQ-016 SHALL never raise load_use for rd=0 or for operands an opcode does not use.

Reset
REQ-017 SHALL on rst_n=0 asynchronously clear out_valid, out_rd, out_imm, out_alu_op and all control outputs to 0.
REQ-018 SHALL hold in_ready=0 and rf_en=0 while rst_n=0, and accept from the first rising edge after release.
REQ-019 SHALL discard any held instruction when reset is asserted mid-operation.

Verification
REQ-020 ADDI, instr=0x0443FFFE -> rf_addr1=3, rf_en=1; next cycle out_valid=1, out_rd=2, out_imm=0xFFFFFFFE, use_imm=1, wr_en=1.
REQ-021 LOAD rd=5 then R-type rs2=5 back-to-back, out_ready=1 -> one cycle in_ready=0, rf_en=0, one bubble (out_valid=0), then R-type accepted.
REQ-022 LOAD rd=0 followed by R-type rs1=0 -> no stall; R-type accepted the next cycle.
REQ-023 out_ready=0 for 3 cycles with a bundle held -> outputs unchanged, in_ready=0, rf_en=0; bundle released on the first out_ready=1.
REQ-024 flush asserted with in_valid=1 and a bundle held -> next cycle out_valid=0; incoming instruction dropped.
REQ-025 opcode 0x3F -> out_illegal=1, wr_en=mem_rd=mem_wr=branch=0; rst_n pulsed low mid-stream -> all outputs 0 immediately.
